// File: rtl/pc_seq_pkg.sv
// ----------------------------------------------------------------------------
// pc_seq_pkg
//   Shared definitions for the IF-stage program-counter sequencer.
//   - seq_state_t      : sequencer FSM encoding (IDLE/RUN/WAIT, 2 bits)
//   - PC_INC           : sequential fetch stride in bytes
//   - RESET_PC_DEFAULT : default PC after reset / while the core is stopped
// ----------------------------------------------------------------------------
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } seq_state_t;

    localparam int unsigned PC_INC           = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : pc_seq_pkg

// File: rtl/pc_next_sel.sv
// ----------------------------------------------------------------------------
// pc_next_sel
//   Combinational next-PC priority mux for the PC sequencer.
//   Priority: jump > branch > pending redirect > stall hold > pc + PC_INC.
//   Redirect targets are word-aligned before being returned; misaligned flags
//   a target whose low two bits were non-zero.
//
// Ports
//   pc              in   PC_W  current program counter
//   jump            in   1     jump request this cycle
//   jump_target     in   PC_W  jump target
//   branch          in   1     taken branch this cycle
//   branch_target   in   PC_W  branch target
//   pending_valid   in   1     a redirect was captured while the fetch waited
//   pending_target  in   PC_W  captured redirect target (unaligned original)
//   stall           in   1     hold PC when no redirect applies
//   next_pc         out  PC_W  selected next PC
//   redirect_taken  out  1     next_pc comes from a redirect target
//   misaligned      out  1     selected redirect target had [1:0] != 0
// ----------------------------------------------------------------------------
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            branch,
    input  logic [PC_W-1:0] branch_target,
    input  logic            pending_valid,
    input  logic [PC_W-1:0] pending_target,
    input  logic            stall,
    output logic [PC_W-1:0] next_pc,
    output logic            redirect_taken,
    output logic            misaligned
);

    logic [PC_W-1:0] target;

    always_comb begin
        target         = pending_target;
        redirect_taken = 1'b1;
        if (jump) begin
            target = jump_target;
        end else if (branch) begin
            target = branch_target;
        end else if (pending_valid) begin
            target = pending_target;
        end else begin
            redirect_taken = 1'b0;
        end
    end

    always_comb begin
        next_pc    = pc;
        misaligned = 1'b0;
        if (redirect_taken) begin
            // Alignment is forced here so pc never carries non-zero low bits.
            next_pc    = {target[PC_W-1:2], 2'b00};
            misaligned = |target[1:0];
        end else if (!stall) begin
            // Wraps modulo 2^PC_W with no overflow indication.
            next_pc = pc + PC_W'(PC_INC);
        end
    end

endmodule : pc_next_sel

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//   Owns the program counter in the IF stage. Steps the PC by PC_INC, applies
//   branch/jump redirects, honours hazard stalls and the instruction-memory
//   ready handshake, and raises a registered one-cycle IF/ID flush after each
//   redirect is loaded.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | stopped; pc held at RESET_PC, no fetch request
//   RUN   | fetching; pc advances whenever imem_ready_i is high
//   WAIT  | fetch not yet served; pc held, redirects captured as pending
//
// Ports
//   clk_i            in   1     clock, rising edge
//   rst_i            in   1     synchronous reset, active high
//   start_i          in   1     run enable; low returns to IDLE
//   stall_i          in   1     hazard stall, hold PC
//   branch_i         in   1     branch taken (resolved in ID)
//   branch_target_i  in   PC_W  branch target
//   jump_i           in   1     jump request
//   jump_target_i    in   PC_W  jump target
//   imem_ready_i     in   1     instruction memory served the current fetch
//   pc_o             out  PC_W  current fetch address
//   imem_req_o       out  1     fetch request valid (RUN or WAIT)
//   flush_o          out  1     one-cycle IF/ID flush after a redirect
//   misalign_o       out  1     one-cycle pulse: loaded target had [1:0]!=0
//   busy_o           out  1     high while in WAIT
// ----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_target_i,
    input  logic            imem_ready_i,
    output logic [PC_W-1:0] pc_o,
    output logic            imem_req_o,
    output logic            flush_o,
    output logic            misalign_o,
    output logic            busy_o
);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic [PC_W-1:0] pend_target_q, pend_target_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;

    logic [PC_W-1:0] sel_next_pc;
    logic            sel_redirect;
    logic            sel_misaligned;

    // Pending is always clear while in RUN, so the same mux serves both the
    // RUN and WAIT->RUN cases without gating pending_valid by state.
    pc_next_sel #(
        .PC_W (PC_W)
    ) u_next_sel (
        .pc             (pc_q),
        .jump           (jump_i),
        .jump_target    (jump_target_i),
        .branch         (branch_i),
        .branch_target  (branch_target_i),
        .pending_valid  (pend_valid_q),
        .pending_target (pend_target_q),
        .stall          (stall_i),
        .next_pc        (sel_next_pc),
        .redirect_taken (sel_redirect),
        .misaligned     (sel_misaligned)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        flush_d       = 1'b0;
        misalign_d    = 1'b0;

        if (!start_i) begin
            // Stopping discards any captured redirect.
            state_d       = ST_IDLE;
            pc_d          = RESET_PC;
            pend_valid_d  = 1'b0;
            pend_target_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // First fetch goes out at RESET_PC.
                    state_d = ST_RUN;
                end
                ST_RUN, ST_WAIT: begin
                    if (imem_ready_i) begin
                        state_d       = ST_RUN;
                        pc_d          = sel_next_pc;
                        flush_d       = sel_redirect;
                        misalign_d    = sel_misaligned;
                        pend_valid_d  = 1'b0;
                        pend_target_d = '0;
                    end else begin
                        state_d = ST_WAIT;
                        // Newest redirect wins; jump beats branch in the
                        // same cycle.
                        if (jump_i) begin
                            pend_valid_d  = 1'b1;
                            pend_target_d = jump_target_i;
                        end else if (branch_i) begin
                            pend_valid_d  = 1'b1;
                            pend_target_d = branch_target_i;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign pc_o       = pc_q;
    assign imem_req_o = (state_q != ST_IDLE);
    assign busy_o     = (state_q == ST_WAIT);
    assign flush_o    = flush_q;
    assign misalign_o = misalign_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_target_i = '0;
    logic        imem_ready_i = 1'b0;
    logic [31:0] pc_o;
    logic        imem_req_o;
    logic        flush_o;
    logic        misalign_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    // Reference model: "running" means the core has been started and issued
    // its first fetch; "blocked" means the last fetch has not been served.
    bit          m_running;
    bit          m_blocked;
    bit          m_have_pend;
    logic [31:0] m_pend;
    logic [31:0] m_pc;
    bit          m_flush;
    bit          m_mis;

    pc_sequencer #(
        .PC_W     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .imem_ready_i    (imem_ready_i),
        .pc_o            (pc_o),
        .imem_req_o      (imem_req_o),
        .flush_o         (flush_o),
        .misalign_o      (misalign_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [31:0] tgt;
        bit          redirect;
        m_flush = 0;
        m_mis   = 0;
        if (rst_i || !start_i) begin
            m_running   = 0;
            m_blocked   = 0;
            m_have_pend = 0;
            m_pc        = RST_PC;
        end else if (!m_running) begin
            m_running = 1;
        end else if (!imem_ready_i) begin
            m_blocked = 1;
            if (jump_i) begin
                m_have_pend = 1; m_pend = jump_target_i;
            end else if (branch_i) begin
                m_have_pend = 1; m_pend = branch_target_i;
            end
        end else begin
            redirect = 1;
            if (jump_i)           tgt = jump_target_i;
            else if (branch_i)    tgt = branch_target_i;
            else if (m_have_pend) tgt = m_pend;
            else                  redirect = 0;
            if (redirect) begin
                m_pc    = tgt & 32'hFFFF_FFFC;
                m_flush = 1;
                m_mis   = (tgt % 4) != 0;
            end else if (!stall_i) begin
                m_pc = m_pc + 32'd4;
            end
            m_blocked   = 0;
            m_have_pend = 0;
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic stl,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt, input logic rdy);
        rst_i = rst; start_i = st; stall_i = stl;
        branch_i = br; branch_target_i = bt;
        jump_i = jp; jump_target_i = jt;
        imem_ready_i = rdy;
        @(posedge clk_i);
        model_update();
        #1;
        check("model_pc",       pc_o,       m_pc);
        check("model_req",      imem_req_o, 32'(m_running));
        check("model_busy",     busy_o,     32'(m_running && m_blocked));
        check("model_flush",    flush_o,    32'(m_flush));
        check("model_misalign", misalign_o, 32'(m_mis));
    endtask

    initial begin
        // 1: reset, start, sequential fetch
        step(1, 0, 0, 0, 0, 0, 0, 1);
        check("rst_pc", pc_o, 32'h0);
        check("rst_req", imem_req_o, 0);
        check("rst_flush", flush_o, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        check("start_pc", pc_o, 32'h0);
        check("start_req", imem_req_o, 1);
        step(0, 1, 0, 0, 0, 0, 0, 1); check("seq_pc4", pc_o, 32'h4);
        step(0, 1, 0, 0, 0, 0, 0, 1); check("seq_pc8", pc_o, 32'h8);
        step(0, 1, 0, 0, 0, 0, 0, 1); check("seq_pc12", pc_o, 32'hC);
        check("seq_flush", flush_o, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1); check("seq_pc16", pc_o, 32'h10);

        // 2: stall, then branch during stall
        step(0, 1, 1, 0, 0, 0, 0, 1);        check("stall_hold", pc_o, 32'h10);
        step(0, 1, 1, 1, 32'h40, 0, 0, 1);   check("stall_br_pc", pc_o, 32'h40);
        check("stall_br_flush", flush_o, 1);
        step(0, 1, 0, 0, 0, 0, 0, 1);        check("post_br_pc", pc_o, 32'h44);
        check("post_br_flush", flush_o, 0);

        // 3: jump beats branch
        step(0, 1, 0, 1, 32'h200, 1, 32'h100, 1);
        check("jmp_pri_pc", pc_o, 32'h100);
        check("jmp_pri_flush", flush_o, 1);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        check("jmp_pri_flush_end", flush_o, 0);

        // 4: memory wait with pending branch
        step(0, 1, 0, 0, 0, 1, 32'h20, 1);   check("to_20", pc_o, 32'h20);
        step(0, 1, 0, 1, 32'h80, 0, 0, 0);   check("wait1_busy", busy_o, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);        check("wait2_busy", busy_o, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);        check("wait3_busy", busy_o, 1);
        check("wait_pc_held", pc_o, 32'h20);
        step(0, 1, 0, 0, 0, 0, 0, 1);        check("pend_pc", pc_o, 32'h80);
        check("pend_flush", flush_o, 1);
        check("pend_busy", busy_o, 0);

        // 5: misaligned target, wraparound
        step(0, 1, 0, 0, 0, 1, 32'h103, 1);  check("mis_pc", pc_o, 32'h100);
        check("mis_pulse", misalign_o, 1);
        step(0, 1, 0, 0, 0, 0, 0, 1);        check("mis_end", misalign_o, 0);
        step(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        check("wrap_pre", pc_o, 32'hFFFF_FFFC);
        check("wrap_pre_mis", misalign_o, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1);        check("wrap_pc", pc_o, 32'h0);
        check("wrap_flush", flush_o, 0);

        // 6: stop mid-WAIT discards pending; reset beats jump
        step(0, 1, 0, 0, 0, 0, 0, 1);        check("pre6_pc", pc_o, 32'h4);
        step(0, 1, 0, 0, 0, 1, 32'h300, 0);  check("w6_busy", busy_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);        check("stop_pc", pc_o, RST_PC);
        check("stop_req", imem_req_o, 0);
        check("stop_busy", busy_o, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1);        check("restart_pc", pc_o, RST_PC);
        step(0, 1, 0, 0, 0, 0, 0, 1);        check("no_pend_pc", pc_o, 32'h4);
        check("no_pend_flush", flush_o, 0);
        step(1, 1, 0, 0, 0, 1, 32'h500, 1);  check("rst_jmp_pc", pc_o, RST_PC);
        check("rst_jmp_flush", flush_o, 0);
        check("rst_jmp_req", imem_req_o, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] bt, jt;
            bt = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 1) == 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) jt[1:0] = 2'b00;
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 24) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, bt,
                 $urandom_range(0, 6) == 0, jt,
                 $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that owns the program counter.
- Sequences PC updates between sequential fetch (+4), branch redirect and jump redirect.
- Honours hazard-unit stalls and an instruction-memory ready handshake, and issues a one-cycle IF/ID flush after every redirect.
- Sits in the IF stage: drives the instruction-memory address and the flush into the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset and while start_i is low
PC_W, 32, program-counter width

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
start_i  input  1  run enable; low forces IDLE
stall_i  input  1  hazard-unit stall; hold PC
branch_i  input  1  branch taken (resolved in ID)
branch_target_i  input  PC_W  branch target
jump_i  input  1  jump request
jump_target_i  input  PC_W  jump target
imem_ready_i  input  1  instruction memory accepted/served current fetch
pc_o  output  PC_W  current fetch address
imem_req_o  output  1  fetch request valid
flush_o  output  1  one-cycle IF/ID flush pulse
misalign_o  output  1  one-cycle pulse: applied target had [1:0]!=0
busy_o  output  1  high in WAIT state

Behaviour:
- Reset (rst_i=1 at edge):
  - pc_o=RESET_PC, state=IDLE, imem_req_o=0, flush_o=0, misalign_o=0, busy_o=0.
  - Pending redirect cleared.
  - rst_i beats every other input.
- start_i=0 (any state, not in reset): next state IDLE, pc_o=RESET_PC, pending cleared, flush_o=0. start_i low beats redirects.
- States: IDLE=0, RUN=1, WAIT=2. imem_req_o=1 in RUN and WAIT, 0 in IDLE (combinational from state).
- IDLE:
  - start_i=1 -> RUN next cycle; pc_o stays RESET_PC, so the first fetch address is RESET_PC.
- RUN, imem_ready_i=1 — next PC priority:
  - jump_i -> jump_target.
  - else branch_i -> branch_target.
  - else stall_i -> hold.
  - else pc_o+4.
  - A redirect wins over stall_i.
- RUN, imem_ready_i=0:
  - -> WAIT; pc_o held.
  - Any redirect this cycle is latched into pending (jump over branch).
- WAIT:
  - pc_o held; busy_o=1.
  - A new redirect overwrites pending.
  - On imem_ready_i=1, apply the first of: current-cycle redirect, else pending, else stall hold, else +4. Then -> RUN and clear pending.
- Redirect application:
  - Target low 2 bits are forced to 0 before loading into pc_o.
  - misalign_o pulses in the same cycle the target is loaded if the original target[1:0]!=0.
  - flush_o is registered: high for exactly the one cycle after the edge that loads a redirect target. Back-to-back redirects give back-to-back flush pulses.
- Arithmetic:
  - pc_o+4 is modulo 2^PC_W: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
  - pc_o[1:0] is always 0.
- Latency: PC update visible one cycle after the qualifying edge; no combinational path from inputs to pc_o.

Decomposition:
- Package pc_seq_pkg:
  - state encoding IDLE/RUN/WAIT (2-bit)
  - PC_INC=4
  - RESET_PC default
- One sub-module, pc_next_sel: a combinational priority mux (jump > branch > pending > stall > +4). It returns next_pc, redirect_taken and misaligned. The FSM and registers stay in pc_sequencer.

Test Plan:
1. Reset then start_i=1, imem_ready_i=1 constant, 4 cycles -> pc_o: 0,0,4,8,12; flush_o stays 0.
2. In RUN at pc=0x10, stall_i=1 for 2 cycles with branch_i=1 and target 0x40 in the second stall cycle -> pc holds 0x10 for one cycle, then 0x40. flush_o=1 the following cycle only.
3. Same cycle jump_i (0x100) and branch_i (0x200) -> pc_o=0x100; one flush pulse.
4. imem_ready_i=0 for 3 cycles at pc=0x20, branch to 0x80 asserted in the first wait cycle only, ready returns -> busy_o=1 for 3 cycles, pc held 0x20, then pc_o=0x80 and flush pulse.
5. Jump to 0x103 -> pc_o=0x100, misalign_o pulse. pc=0xFFFF_FFFC sequential -> 0x0.
6. Mid-WAIT with a pending redirect, start_i=0 -> pc_o=RESET_PC, IDLE, pending discarded. Then rst_i=1 together with jump_i -> reset values, no flush.
